rom_download_ctrl: RTL and testbench
====================================

// Module: rom_download_ctrl
// PURPOSE
//   Sequences the HPS ROM download into the sprint2 core's ROM regions and controls the core's reset.
//   - Decodes the linear ioctl address into per-region write strobes and offsets.
//   - Holds the game in reset during and after a download.
//   - Releases the game reset only after a settle delay.
//   - Sits between hps_io (ioctl_*) and the sprint2 instance (dn_* / Reset_n).
// PARAMETERS
//   ADDR_W       17     width of dn_addr
//   OFS_W        13     width of rom_addr (region-local offset)
//   SETTLE_CYC   1024   cycles game reset stays low after download ends (>=1)
//   EXPECT_SUM   8'h00  expected 8-bit additive checksum (ROM_CHECKSUM_EN only)
// PORTS
//   clk_sys       in   1        system clock (12 MHz); all logic on rising edge
//   Reset_n       in   1        synchronous, active-low reset
//   dn_download   in   1        HPS download in progress
//   dn_wr         in   1        one-cycle write strobe from HPS
//   dn_addr       in   ADDR_W   linear byte address
//   dn_data       in   8        byte to write
//   rom_we        out  4        one-hot region write enable, one-cycle pulse
//   rom_addr      out  OFS_W    region-local byte offset (dn_addr - base)
//   rom_data      out  8        registered dn_data
//   game_reset_n  out  1        reset to sprint2 core, active low
//   busy          out  1        1 in LOAD or SETTLE
//   err_range     out  1        sticky: a write hit an address outside all regions
//   short_load    out  1        download ended with fewer than TOTAL_BYTES accepted
//   sum_ok        out  1        checksum matched (ROM_CHECKSUM_EN only, else 0)
// BEHAVIOUR
//   - Reset (Reset_n=0 at an edge): state=BOOT.
//     Outputs take these values the next cycle: rom_we=0, rom_addr=0, rom_data=0, game_reset_n=0, busy=0,
//     err_range=0, short_load=0, sum_ok=0. Byte counter, settle counter and sum are cleared.
//   - FSM states BOOT, LOAD, SETTLE, RUN:
//       BOOT->LOAD   when dn_download=1; the game stays in reset until the first download completes.
//       LOAD->SETTLE on the first cycle with dn_download=0; settle counter loads SETTLE_CYC-1.
//       SETTLE->RUN  when the counter reaches 0; the counter decrements once per cycle.
//       SETTLE->LOAD and RUN->LOAD on dn_download=1.
//   - game_reset_n is a registered output: 1 only while state==RUN. It drops the cycle after the LOAD entry edge.
//   - LOAD entry clears err_range, short_load, sum_ok, the byte counter and the sum.
//   - Write path: a write is accepted when dn_wr=1 and state==LOAD at the same edge.
//     That edge is LOAD entry or any edge in LOAD, including the edge at which dn_download falls.
//     The write is decoded against package region table REG_BASE[i]/REG_SIZE[i].
//     In range, i.e. REG_BASE[i] <= dn_addr < REG_BASE[i]+REG_SIZE[i]:
//       rom_we[i]=1 for exactly one cycle at N+1, rom_addr=dn_addr-REG_BASE[i] (truncated to OFS_W),
//       rom_data=dn_data. The byte counter increments, saturating at 2^ADDR_W-1.
//     Out of range: rom_we stays 0 and err_range is set at N+1.
//     Latency is fixed at 1 cycle; back-to-back strobes give back-to-back pulses.
//   - dn_wr outside LOAD (BOOT, SETTLE, RUN) is ignored: no we, no counter change.
//   - On LOAD->SETTLE: short_load <= (byte counter < TOTAL_BYTES).
//     Extra bytes are allowed; duplicate addresses overwrite and each counts.
//   - Reset mid-download: abort to BOOT; any pending rom_we pulse is suppressed.
// CONFIGURATION
//   `ROM_CHECKSUM_EN defined:
//     - Each accepted in-range byte is added into an 8-bit wrapping sum.
//     - On LOAD->SETTLE: sum_ok <= (sum==EXPECT_SUM).
//     - If sum!=EXPECT_SUM, SETTLE->RUN is blocked; the FSM stays in SETTLE with game_reset_n=0
//       until the next download.
//   Not defined:
//     - No summing; sum_ok is tied 0; SETTLE->RUN depends only on the counter.
//   Port list is identical in both builds.
// STRUCTURE
//   - Package sprint2_rom_pkg holds:
//     - state enum {BOOT,LOAD,SETTLE,RUN};
//     - NUM_REGIONS=4;
//     - REG_BASE = {17'h0000,17'h2000,17'h2800,17'h3000};
//     - REG_SIZE = {17'h2000,17'h0800,17'h0800,17'h0100}, covering program ROM, tile ROM, car ROM and sync/video PROMs;
//     - TOTAL_BYTES = sum of REG_SIZE = 17'h3100.
//   - One sub-module, rom_region_decode: combinational address -> {hit, one-hot idx, offset}.
//     It is instantiated once; the FSM, counters and output registers stay in the top.
// TESTING
//   1. Reset released, dn_download=0 -> state BOOT, game_reset_n=0 indefinitely, rom_we=0.
//   2. Full load, 0x3100 strobes at addr 0..0x30FF:
//      - write to 0x2805 pulses rom_we=4'b0100, rom_addr=0x005, data echoed, 1 cycle late;
//      - after the download falls, game_reset_n rises exactly SETTLE_CYC+1 cycles later;
//      - short_load=0, err_range=0.
//   3. Strobe at 0x3100 and at 0x1FFFF -> no rom_we, err_range=1; cleared at next download start.
//   4. Download ended after 0x1000 bytes -> short_load=1; game still released after SETTLE_CYC.
//   5. In RUN: dn_wr without dn_download -> no rom_we; then dn_download rises -> game_reset_n=0 next cycle.
//      Reset_n=0 in the middle of LOAD -> the pulse due next cycle is suppressed, BOOT.
//   6. With ROM_CHECKSUM_EN, EXPECT_SUM=8'h5A, data summing to 8'h5B -> sum_ok=0, game_reset_n stays 0;
//      a reload with a matching sum -> sum_ok=1, release.

Source files
------------

// File: rtl/sprint2_rom_pkg.sv
// Shared types and the ROM region map for the sprint2 download controller.
// Regions in order: program ROM, tile ROM, car ROM, sync/video PROMs.
package sprint2_rom_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } dl_state_e;

  localparam int NUM_REGIONS = 4;
  localparam int REG_W       = 17;

  localparam logic [REG_W-1:0] REG_BASE [NUM_REGIONS] =
    '{17'h00000, 17'h02000, 17'h02800, 17'h03000};
  localparam logic [REG_W-1:0] REG_SIZE [NUM_REGIONS] =
    '{17'h02000, 17'h00800, 17'h00800, 17'h00100};

  localparam logic [REG_W-1:0] TOTAL_BYTES = 17'h03100;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a linear download address into a one-hot region
// select plus the region-local offset; hit=0 when no region matches.
module rom_region_decode
  import sprint2_rom_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int OFS_W  = 13
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic                   hit,
  output logic [NUM_REGIONS-1:0] sel,
  output logic [OFS_W-1:0]       ofs
);

  // Regions never overlap, so at most one iteration matches.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    ofs = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if ((addr >= ADDR_W'(REG_BASE[i])) &&
          (addr <  ADDR_W'(REG_BASE[i] + REG_SIZE[i]))) begin
        hit    = 1'b1;
        sel[i] = 1'b1;
        ofs    = OFS_W'(addr - ADDR_W'(REG_BASE[i]));
      end
    end
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// HPS ROM download sequencer for sprint2: region write strobes and game reset.
// Optional macro ROM_CHECKSUM_EN gates game release on an 8-bit additive checksum.
module rom_download_ctrl
  import sprint2_rom_pkg::*;
#(
  parameter int          ADDR_W     = 17,
  parameter int          OFS_W      = 13,
  parameter int          SETTLE_CYC = 1024,
  parameter logic [7:0]  EXPECT_SUM = 8'h00
) (
  input  logic                   clk_sys,
  input  logic                   Reset_n,
  input  logic                   dn_download,
  input  logic                   dn_wr,
  input  logic [ADDR_W-1:0]      dn_addr,
  input  logic [7:0]             dn_data,
  output logic [NUM_REGIONS-1:0] rom_we,
  output logic [OFS_W-1:0]       rom_addr,
  output logic [7:0]             rom_data,
  output logic                   game_reset_n,
  output logic                   busy,
  output logic                   err_range,
  output logic                   short_load,
  output logic                   sum_ok
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  dl_state_e               state_q, state_d;
  logic [CNT_W-1:0]        settle_cnt_q, settle_cnt_d;
  logic [ADDR_W-1:0]       byte_cnt_q, byte_cnt_d, byte_cnt_base;
  logic [NUM_REGIONS-1:0]  rom_we_q, rom_we_d;
  logic [OFS_W-1:0]        rom_addr_q, rom_addr_d;
  logic [7:0]              rom_data_q, rom_data_d;
  logic                    game_reset_n_q, game_reset_n_d;
  logic                    err_range_q, err_range_d;
  logic                    short_load_q, short_load_d;

  logic                    dec_hit;
  logic [NUM_REGIONS-1:0]  dec_sel;
  logic [OFS_W-1:0]        dec_ofs;
  logic                    load_entry, load_exit, wr_acc, wr_hit, wr_miss;
  logic                    settle_gate;

  rom_region_decode #(
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) u_decode (
    .addr (dn_addr),
    .hit  (dec_hit),
    .sel  (dec_sel),
    .ofs  (dec_ofs)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (dn_download) state_d = LOAD;
      LOAD:    if (!dn_download) state_d = SETTLE;
      SETTLE: begin
        if (dn_download) state_d = LOAD;
        else if ((settle_cnt_q == '0) && settle_gate) state_d = RUN;
      end
      RUN:     if (dn_download) state_d = LOAD;
      default: state_d = BOOT;
    endcase
  end

  // dn_wr is a single-cycle strobe with no back-pressure: a byte is taken at any
  // edge where dn_wr=1 and the FSM is in, or entering, LOAD; otherwise it is dropped.
  assign load_entry = (state_d == LOAD) && (state_q != LOAD);
  assign load_exit  = (state_q == LOAD) && (state_d == SETTLE);
  assign wr_acc     = dn_wr && ((state_q == LOAD) || (state_d == LOAD));
  assign wr_hit     = wr_acc && dec_hit;
  assign wr_miss    = wr_acc && !dec_hit;

  always_comb begin
    rom_we_d       = wr_hit ? dec_sel : '0;
    rom_addr_d     = wr_hit ? dec_ofs : rom_addr_q;
    rom_data_d     = wr_hit ? dn_data : rom_data_q;
    game_reset_n_d = (state_q == RUN);

    byte_cnt_base  = load_entry ? '0 : byte_cnt_q;
    byte_cnt_d     = (wr_hit && (byte_cnt_base != '1)) ? byte_cnt_base + ADDR_W'(1)
                                                       : byte_cnt_base;

    err_range_d    = (load_entry ? 1'b0 : err_range_q) | wr_miss;

    // The byte taken on the falling-download edge still counts toward the total.
    short_load_d   = short_load_q;
    if (load_entry)     short_load_d = 1'b0;
    else if (load_exit) short_load_d = (byte_cnt_d < ADDR_W'(TOTAL_BYTES));

    settle_cnt_d   = settle_cnt_q;
    if (load_exit)
      settle_cnt_d = CNT_W'(SETTLE_CYC - 1);
    else if ((state_q == SETTLE) && (settle_cnt_q != '0))
      settle_cnt_d = settle_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (!Reset_n) begin
      state_q        <= BOOT;
      settle_cnt_q   <= '0;
      byte_cnt_q     <= '0;
      rom_we_q       <= '0;
      rom_addr_q     <= '0;
      rom_data_q     <= '0;
      game_reset_n_q <= 1'b0;
      err_range_q    <= 1'b0;
      short_load_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      rom_we_q       <= rom_we_d;
      rom_addr_q     <= rom_addr_d;
      rom_data_q     <= rom_data_d;
      game_reset_n_q <= game_reset_n_d;
      err_range_q    <= err_range_d;
      short_load_q   <= short_load_d;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       sum_ok_q, sum_ok_d;

  always_comb begin
    sum_d    = (load_entry ? 8'h00 : sum_q) + (wr_hit ? dn_data : 8'h00);
    sum_ok_d = sum_ok_q;
    if (load_entry)     sum_ok_d = 1'b0;
    else if (load_exit) sum_ok_d = (sum_d == EXPECT_SUM);
  end

  always_ff @(posedge clk_sys) begin
    if (!Reset_n) begin
      sum_q    <= 8'h00;
      sum_ok_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      sum_ok_q <= sum_ok_d;
    end
  end

  // A bad checksum parks the FSM in SETTLE until the next download.
  assign settle_gate = sum_ok_q;
  assign sum_ok      = sum_ok_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^EXPECT_SUM;
  assign settle_gate = 1'b1;
  assign sum_ok      = 1'b0;
`endif

  assign rom_we       = rom_we_q;
  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign game_reset_n = game_reset_n_q;
  assign busy         = (state_q == LOAD) || (state_q == SETTLE);
  assign err_range    = err_range_q;
  assign short_load   = short_load_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl: region decode table, full/short loads,
// settle timing, ignored strobes, reset mid-download and (ROM_CHECKSUM_EN) checksum gating.
module tb_rom_download_ctrl;

  localparam int         SETTLE = 16;
  localparam logic [7:0] ESUM   = 8'h5A;
`ifdef ROM_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        Reset_n;
  logic        dn_download;
  logic        dn_wr;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic [3:0]  rom_we;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic        game_reset_n, busy, err_range, short_load, sum_ok;

  int n_vec = 0;
  int n_err = 0;
  bit sb_en = 1'b0;
  logic [24:0] exp_q[$];

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [3:0]  we;
    logic [12:0] ofs;
    logic        err;
  } vec_t;
  vec_t tbl [12];

  rom_download_ctrl #(
    .ADDR_W     (17),
    .OFS_W      (13),
    .SETTLE_CYC (SETTLE),
    .EXPECT_SUM (ESUM)
  ) dut (
    .clk_sys      (clk_sys),
    .Reset_n      (Reset_n),
    .dn_download  (dn_download),
    .dn_wr        (dn_wr),
    .dn_addr      (dn_addr),
    .dn_data      (dn_data),
    .rom_we       (rom_we),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .game_reset_n (game_reset_n),
    .busy         (busy),
    .err_range    (err_range),
    .short_load   (short_load),
    .sum_ok       (sum_ok)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_sel(input logic [16:0] a);
    if (a < 17'h02000)      return 4'b0001;
    else if (a < 17'h02800) return 4'b0010;
    else if (a < 17'h03000) return 4'b0100;
    else if (a < 17'h03100) return 4'b1000;
    else                    return 4'b0000;
  endfunction

  function automatic logic [12:0] exp_ofs(input logic [16:0] a);
    logic [16:0] base;
    if (a < 17'h02000)      base = 17'h00000;
    else if (a < 17'h02800) base = 17'h02000;
    else if (a < 17'h03000) base = 17'h02800;
    else                    base = 17'h03000;
    return 13'(a - base);
  endfunction

  // scoreboard: every rom_we pulse must match the oldest expected write
  always @(negedge clk_sys) begin
    if (sb_en && (rom_we != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        chk("sb_spurious_we", 32'(rom_we), 32'h0);
      end else begin
        chk("sb_write", 32'({rom_we, rom_addr, rom_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver: one download of n sequential bytes; last byte forces the in-range sum to target
  task automatic do_load(input int base, input int n, input logic [7:0] target,
                         output logic [7:0] s);
    logic [16:0] a;
    logic [7:0]  d;
    logic [3:0]  sel;
    s = 8'h00;
    dn_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      a   = 17'(base + i);
      d   = (i == n - 1) ? 8'(target - s) : 8'($urandom_range(0, 255));
      sel = exp_sel(a);
      dn_wr = 1'b1; dn_addr = a; dn_data = d;
      if (sel != 4'b0000) begin
        exp_q.push_back({sel, exp_ofs(a), d});
        s = s + d;
      end
      @(negedge clk_sys);
    end
    dn_wr = 1'b0;
    dn_download = 1'b0;
  endtask

  // called with dn_download just dropped; k counts negedges after the falling-download edge
  task automatic settle_check(input string tag, input logic exp_short, input logic exp_err,
                              input logic [7:0] s);
    logic exp_ok, exp_rel;
    int   first_k;
    exp_ok  = CKS_EN && (s == ESUM);
    exp_rel = !CKS_EN || exp_ok;
    first_k = -1;
    for (int k = 0; k < SETTLE + 10; k++) begin
      @(negedge clk_sys);
      if (k == 0) begin
        chk({tag, "_busy"},   32'(busy),         32'h1);
        chk({tag, "_short"},  32'(short_load),   32'(exp_short));
        chk({tag, "_err"},    32'(err_range),    32'(exp_err));
        chk({tag, "_sum_ok"}, 32'(sum_ok),       32'(exp_ok));
        chk({tag, "_gr_low"}, 32'(game_reset_n), 32'h0);
      end
      if (game_reset_n && (first_k < 0)) first_k = k;
    end
    chk({tag, "_release_k"}, 32'(first_k), exp_rel ? 32'(SETTLE + 1) : 32'hFFFF_FFFF);
  endtask

  initial begin
    logic [7:0] s, tsum;

    tbl = '{
      '{17'h00000, 8'h11, 4'b0001, 13'h0000, 1'b0},
      '{17'h01FFF, 8'h22, 4'b0001, 13'h1FFF, 1'b0},
      '{17'h02000, 8'h33, 4'b0010, 13'h0000, 1'b0},
      '{17'h027FF, 8'h44, 4'b0010, 13'h07FF, 1'b0},
      '{17'h02800, 8'h55, 4'b0100, 13'h0000, 1'b0},
      '{17'h02805, 8'hA5, 4'b0100, 13'h0005, 1'b0},
      '{17'h02FFF, 8'h66, 4'b0100, 13'h07FF, 1'b0},
      '{17'h03000, 8'h77, 4'b1000, 13'h0000, 1'b0},
      '{17'h030FF, 8'h88, 4'b1000, 13'h00FF, 1'b0},
      '{17'h03100, 8'h99, 4'b0000, 13'h0000, 1'b1},
      '{17'h1FFFF, 8'hAA, 4'b0000, 13'h0000, 1'b1},
      '{17'h00010, 8'hBB, 4'b0001, 13'h0010, 1'b1}
    };

    // reset
    Reset_n = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    repeat (2) @(negedge clk_sys);
    chk("rst_rom_we",    32'(rom_we),       32'h0);
    chk("rst_rom_addr",  32'(rom_addr),     32'h0);
    chk("rst_rom_data",  32'(rom_data),     32'h0);
    chk("rst_gr",        32'(game_reset_n), 32'h0);
    chk("rst_busy",      32'(busy),         32'h0);
    chk("rst_err",       32'(err_range),    32'h0);
    chk("rst_short",     32'(short_load),   32'h0);
    chk("rst_sum_ok",    32'(sum_ok),       32'h0);
    Reset_n = 1'b1;
    sb_en = 1'b1;

    // BOOT idle: game held in reset, strobes ignored
    dn_wr = 1'b1; dn_addr = 17'h00005; dn_data = 8'h3C;
    @(negedge clk_sys);
    chk("boot_wr_ignored", 32'(rom_we), 32'h0);
    dn_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      chk("boot_gr_low", 32'(game_reset_n), 32'h0);
    end

    // region decode table, first byte on the LOAD entry edge
    sb_en = 1'b0;
    tsum = 8'h00;
    dn_download = 1'b1;
    for (int i = 0; i < 12; i++) begin
      dn_wr = 1'b1; dn_addr = tbl[i].addr; dn_data = tbl[i].data;
      if (tbl[i].we != 4'b0000) tsum = tsum + tbl[i].data;
      @(negedge clk_sys);
      chk($sformatf("tbl%0d_we", i), 32'(rom_we), 32'(tbl[i].we));
      if (tbl[i].we != 4'b0000) begin
        chk($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(tbl[i].ofs));
        chk($sformatf("tbl%0d_data", i), 32'(rom_data), 32'(tbl[i].data));
      end
      chk($sformatf("tbl%0d_err", i), 32'(err_range), 32'(tbl[i].err));
    end
    dn_wr = 1'b0; dn_download = 1'b0;
    settle_check("tbl", 1'b1, 1'b1, tsum);
    sb_en = 1'b1;

    // full image; err_range from the previous download must clear
    do_load(0, 'h3100, ESUM, s);
    settle_check("full", 1'b0, 1'b0, s);

    // RUN: strobe without download ignored; download start drops game reset
    dn_wr = 1'b1; dn_addr = 17'h00010; dn_data = 8'hEE;
    @(negedge clk_sys);
    chk("run_wr_ignored", 32'(rom_we), 32'h0);
    chk("run_gr_high", 32'(game_reset_n), 32'h1);
    dn_wr = 1'b0;
    dn_download = 1'b1;
    @(negedge clk_sys);
    chk("entry_busy", 32'(busy), 32'h1);
    chk("entry_gr_still_high", 32'(game_reset_n), 32'h1);
    @(negedge clk_sys);
    chk("entry_gr_dropped", 32'(game_reset_n), 32'h0);

    // reset in the middle of LOAD swallows the strobe issued with it
    dn_wr = 1'b1; dn_addr = 17'h02001; dn_data = 8'hAB; Reset_n = 1'b0;
    @(negedge clk_sys);
    chk("midrst_we",   32'(rom_we),       32'h0);
    chk("midrst_addr", 32'(rom_addr),     32'h0);
    chk("midrst_busy", 32'(busy),         32'h0);
    chk("midrst_gr",   32'(game_reset_n), 32'h0);
    dn_wr = 1'b0; dn_download = 1'b0; Reset_n = 1'b1;
    @(negedge clk_sys);
    chk("midrst_boot_busy", 32'(busy), 32'h0);
    chk("midrst_quiet_we",  32'(rom_we), 32'h0);

    // short load still releases after the settle delay
    do_load(0, 'h1000, ESUM, s);
    settle_check("short", 1'b1, 1'b0, s);

`ifdef ROM_CHECKSUM_EN
    // bad checksum parks in SETTLE, matching reload releases
    do_load('h3000, 16, 8'h5B, s);
    settle_check("cks_bad", 1'b1, 1'b0, s);
    chk("cks_bad_parked_busy", 32'(busy), 32'h1);
    do_load('h3000, 16, ESUM, s);
    settle_check("cks_good", 1'b1, 1'b0, s);
`endif

    repeat (3) @(negedge clk_sys);
    chk("sb_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
